// File: rtl/rf_wb_arbiter_if.sv
// Requester-side write-back bus: valid/ready handshake with per-requester
// destination address and data, packed requester i at slice i.
interface rf_wb_arbiter_if #(
   parameter int NREQ = 3,
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*XLEN-1:0] req_data;

   modport master (
      output req_valid,
      input  req_ready,
      output req_addr,
      output req_data
   );

   modport slave (
      input  req_valid,
      output req_ready,
      input  req_addr,
      input  req_data
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file write port.
// Optional RF_WB_FWD_EN exposes the in-flight write to two read ports.
module rf_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32,
   parameter int AW   = 5,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_stall,
   rf_wb_arbiter_if.slave  req,
   output logic            wr_en,
   output logic [AW-1:0]   wr_addr,
   output logic [XLEN-1:0] wr_data,
   output logic [IW-1:0]   grant_id,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic            rs1_fwd_hit,
   output logic            rs2_fwd_hit,
   output logic [XLEN-1:0] rs1_fwd_data,
   output logic [XLEN-1:0] rs2_fwd_data
);

   logic [IW-1:0]   last_q, last_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [XLEN-1:0] wr_data_q, wr_data_d;
   logic [IW-1:0]   gid_q, gid_d;

   logic [IW-1:0]   gnt_idx;
   logic            found;
   logic            grant_ok;
   logic [AW-1:0]   sel_addr;
   logic [XLEN-1:0] sel_data;

   // Search starts just after the last granted index and wraps.
   always_comb begin
      int idx;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_q) + k) % NREQ;
         if (!found && req.req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx[IW-1:0];
         end
      end
   end

   assign grant_ok = found && !wb_stall && !reset;
   assign sel_addr = req.req_addr[int'(gnt_idx)*AW +: AW];
   assign sel_data = req.req_data[int'(gnt_idx)*XLEN +: XLEN];

   always_comb begin
      req.req_ready = '0;
      if (grant_ok) req.req_ready[gnt_idx] = 1'b1;
   end

   // x0 writes still consume the grant but leave the write port idle.
   always_comb begin
      last_d    = grant_ok ? gnt_idx : last_q;
      wr_en_d   = grant_ok && (sel_addr != '0);
      wr_addr_d = wr_en_d ? sel_addr : wr_addr_q;
      wr_data_d = wr_en_d ? sel_data : wr_data_q;
      gid_d     = wr_en_d ? gnt_idx  : gid_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q    <= IW'(NREQ - 1);
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         gid_q     <= '0;
      end else begin
         last_q    <= last_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         gid_q     <= gid_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign grant_id = gid_q;

`ifdef RF_WB_FWD_EN
   assign rs1_fwd_hit  = wr_en_q && (wr_addr_q == rs1_addr)
                         && (rs1_addr != '0);
   assign rs2_fwd_hit  = wr_en_q && (wr_addr_q == rs2_addr)
                         && (rs2_addr != '0);
   assign rs1_fwd_data = wr_data_q;
   assign rs2_fwd_data = wr_data_q;
`else
   logic unused_rs;
   assign unused_rs    = ^{rs1_addr, rs2_addr};
   assign rs1_fwd_hit  = 1'b0;
   assign rs2_fwd_hit  = 1'b0;
   assign rs1_fwd_data = '0;
   assign rs2_fwd_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: round-robin order, x0 drop,
// stall, mid-operation reset, same destination and forwarding.
module tb_rf_wb_arbiter;
   localparam int NREQ = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            wb_stall;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [1:0]      grant_id;
   logic [AW-1:0]   rs1_addr, rs2_addr;
   logic            rs1_fwd_hit, rs2_fwd_hit;
   logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;

   int checks = 0;
   int errors = 0;

   rf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

   rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_stall     (wb_stall),
      .req          (bus.slave),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .grant_id     (grant_id),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_fwd_hit  (rs1_fwd_hit),
      .rs2_fwd_hit  (rs2_fwd_hit),
      .rs1_fwd_data (rs1_fwd_data),
      .rs2_fwd_data (rs2_fwd_data)
   );

   always #5 clk = ~clk;

   task automatic set_req(input int i, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d);
      bus.req_addr[i*AW +: AW]     = a;
      bus.req_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic test_reset;
      reset         = 1'b1;
      wb_stall      = 1'b0;
      bus.req_valid = 3'b111;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      rs1_addr      = '0;
      rs2_addr      = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({wr_en, wr_addr, wr_data, grant_id} !== '0) begin
         errors++;
         $display("FAIL reset_regs: got en=%b a=%0d d=%h g=%0d want 0",
                  wr_en, wr_addr, wr_data, grant_id);
      end
      checks++;
      if (bus.req_ready !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: got %b want 000", bus.req_ready);
      end
      reset         = 1'b0;
      bus.req_valid = '0;
   endtask

   task automatic test_round_robin;
      logic [NREQ-1:0] er;
      int g;
      bus.req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < NREQ; i++)
            set_req(i, AW'(10 + i), 32'hA000_0000 + 32'(c * 16 + i));
         g  = c % NREQ;
         er = NREQ'(1) << g;
         #1;
         checks++;
         if (bus.req_ready !== er) begin
            errors++;
            $display("FAIL rr_ready%0d: got %b want %b", c,
                     bus.req_ready, er);
         end
         @(negedge clk);
         checks++;
         if (wr_en !== 1'b1 || wr_addr !== AW'(10 + g) ||
             wr_data !== 32'hA000_0000 + 32'(c * 16 + g) ||
             grant_id !== 2'(g)) begin
            errors++;
            $display("FAIL rr_write%0d: got en=%b a=%0d d=%h g=%0d want 1 %0d %h %0d",
                     c, wr_en, wr_addr, wr_data, grant_id,
                     10 + g, 32'hA000_0000 + 32'(c * 16 + g), g);
         end
      end
      bus.req_valid = '0;
   endtask

   task automatic test_single;
      bus.req_valid = 3'b010;
      set_req(1, 5'd5, 32'hDEAD_BEEF);
      #1;
      checks++;
      if (bus.req_ready !== 3'b010) begin
         errors++;
         $display("FAIL single_ready: got %b want 010", bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd5 ||
          wr_data !== 32'hDEAD_BEEF || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL single_write: got en=%b a=%0d d=%h g=%0d want 1 5 deadbeef 1",
                  wr_en, wr_addr, wr_data, grant_id);
      end
      bus.req_valid = '0;
   endtask

   task automatic test_x0;
      bus.req_valid = 3'b100;
      set_req(2, 5'd0, 32'h0000_1234);
      #1;
      checks++;
      if (bus.req_ready !== 3'b100) begin
         errors++;
         $display("FAIL x0_ready: got %b want 100", bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd5 ||
          wr_data !== 32'hDEAD_BEEF || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL x0_write: got en=%b a=%0d d=%h g=%0d want 0 5 deadbeef 1",
                  wr_en, wr_addr, wr_data, grant_id);
      end
      bus.req_valid = 3'b111;
      set_req(0, 5'd3, 32'h0000_0333);
      set_req(1, 5'd4, 32'h0000_0444);
      set_req(2, 5'd6, 32'h0000_0666);
      #1;
      checks++;
      if (bus.req_ready !== 3'b001) begin
         errors++;
         $display("FAIL x0_next_ready: got %b want 001", bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd3 ||
          wr_data !== 32'h0000_0333 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL x0_next_write: got en=%b a=%0d d=%h g=%0d want 1 3 333 0",
                  wr_en, wr_addr, wr_data, grant_id);
      end
   endtask

   task automatic test_stall;
      bus.req_valid = 3'b111;
      wb_stall      = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (bus.req_ready !== 3'b000) begin
            errors++;
            $display("FAIL stall_ready%0d: got %b want 000", c,
                     bus.req_ready);
         end
         @(negedge clk);
         checks++;
         if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_wren%0d: got %b want 0", c, wr_en);
         end
      end
      wb_stall = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 3'b010) begin
         errors++;
         $display("FAIL stall_resume: got %b want 010", bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd4 || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL stall_resume_wr: got en=%b a=%0d g=%0d want 1 4 1",
                  wr_en, wr_addr, grant_id);
      end
      bus.req_valid = '0;
   endtask

   task automatic test_reset_mid;
      bus.req_valid = 3'b001;
      set_req(0, 5'd7, 32'h0000_0777);
      #1;
      checks++;
      if (bus.req_ready !== 3'b001) begin
         errors++;
         $display("FAIL rmid_ready: got %b want 001", bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd7) begin
         errors++;
         $display("FAIL rmid_grant_wr: got en=%b a=%0d want 1 7",
                  wr_en, wr_addr);
      end
      reset         = 1'b1;
      bus.req_valid = 3'b111;
      #1;
      checks++;
      if (bus.req_ready !== 3'b000) begin
         errors++;
         $display("FAIL rmid_ready_in_reset: got %b want 000",
                  bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd0) begin
         errors++;
         $display("FAIL rmid_discard: got en=%b a=%0d want 0 0",
                  wr_en, wr_addr);
      end
      reset = 1'b0;
      set_req(0, 5'd8, 32'h0000_0888);
      #1;
      checks++;
      if (bus.req_ready !== 3'b001) begin
         errors++;
         $display("FAIL rmid_first: got %b want 001", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = '0;
   endtask

   task automatic test_same_dest;
      bus.req_valid = 3'b011;
      set_req(0, 5'd3, 32'h0000_0A0A);
      set_req(1, 5'd3, 32'h0000_0B0B);
      #1;
      checks++;
      if (bus.req_ready !== 3'b010) begin
         errors++;
         $display("FAIL same_first: got %b want 010", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 3'b001;
      #1;
      checks++;
      if (wr_data !== 32'h0000_0B0B || bus.req_ready !== 3'b001) begin
         errors++;
         $display("FAIL same_retry: got d=%h rdy=%b want 00000b0b 001",
                  wr_data, bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 32'h0000_0A0A ||
          grant_id !== 2'd0) begin
         errors++;
         $display("FAIL same_second: got en=%b d=%h g=%0d want 1 a0a 0",
                  wr_en, wr_data, grant_id);
      end
      bus.req_valid = '0;
   endtask

   task automatic test_fwd;
      bus.req_valid = 3'b100;
      set_req(2, 5'd9, 32'h0000_0999);
      @(negedge clk);
      rs1_addr = 5'd9;
      rs2_addr = 5'd0;
      bus.req_valid = '0;
      #1;
`ifdef RF_WB_FWD_EN
      checks++;
      if (rs1_fwd_hit !== 1'b1 || rs1_fwd_data !== 32'h0000_0999 ||
          rs2_fwd_hit !== 1'b0) begin
         errors++;
         $display("FAIL fwd_hit: got h1=%b d1=%h h2=%b want 1 999 0",
                  rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit);
      end
`else
      checks++;
      if (rs1_fwd_hit !== 1'b0 || rs2_fwd_hit !== 1'b0 ||
          rs1_fwd_data !== '0 || rs2_fwd_data !== '0) begin
         errors++;
         $display("FAIL fwd_off: got h1=%b h2=%b d1=%h d2=%h want zeros",
                  rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data);
      end
`endif
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd9 || grant_id !== 2'd2) begin
         errors++;
         $display("FAIL fwd_write: got en=%b a=%0d g=%0d want 1 9 2",
                  wr_en, wr_addr, grant_id);
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_single();
      test_x0();
      test_stall();
      test_reset_mid();
      test_same_dest();
      test_fwd();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 32x32 integer register file. Several producers (ALU, load unit, multiplier) compete for the register file's single write port. The block grants one requester per cycle with round-robin fairness, drops writes to x0, and drives registered write-enable/address/data into the register file one cycle after the grant. An optional forwarding path exposes the in-flight write to the two read ports.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- wb_stall  in  1  when high, no grant is issued this cycle
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant (combinational, one-hot or zero)
- req_addr  in  NREQ*AW  destination register; requester i in bits [i*AW +: AW]
- req_data  in  NREQ*XLEN  write data; requester i in bits [i*XLEN +: XLEN]
- wr_en  out  1  register file write enable (registered)
- wr_addr  out  AW  register file write address (registered)
- wr_data  out  XLEN  register file write data (registered)
- grant_id  out  clog2(NREQ)  index of the requester behind the current wr_* (registered)
- rs1_addr, rs2_addr  in  AW  read addresses (used only with RF_WB_FWD_EN)
- rs1_fwd_hit, rs2_fwd_hit  out  1  in-flight write matches the read address (RF_WB_FWD_EN)
- rs1_fwd_data, rs2_fwd_data  out  XLEN  forwarded data (RF_WB_FWD_EN)

## Operation
- Handshake: transfer of requester i occurs when req_valid[i] && req_ready[i]. A requester holds valid, addr and data stable until the transfer.
- At most one req_ready bit is high per cycle. req_ready[i] is never high when req_valid[i] is low.
- Round-robin:
  - A pointer `last` records the most recently granted index.
  - The search starts at (last+1) mod NREQ and grants the first valid requester found.
  - `last` updates only on a transfer.
  - Reset value of `last` is NREQ-1, so requester 0 has top priority after reset.
- Fairness: a requester holding valid continuously is granted within NREQ non-stalled cycles.
- wb_stall=1: all req_ready=0 and `last` is unchanged. wr_en goes to 0 on the next edge.
- x0 writes: a request with addr=0 is still accepted (ready pulses, pointer advances). The next cycle's wr_en=0, and wr_addr/wr_data keep their previous values.
- Non-zero transfer: on the next edge, wr_en=1, wr_addr=req_addr[i], wr_data=req_data[i], grant_id=i.
- No transfer in a cycle: on the next edge, wr_en=0, and wr_addr, wr_data and grant_id hold.
- Same destination from two requesters in one cycle: only the granted one transfers. The other retries in a later cycle; no merging.

## Timing
- Grant to register file write visible on wr_*: 1 cycle. Throughput: 1 write per cycle.
- req_ready depends combinationally on req_valid, wb_stall and `last`; there is no path from req_data to req_ready.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, grant_id=0, `last`=NREQ-1, req_ready=0 while reset is high.
- Reset mid-operation: any pending registered write is discarded (wr_en=0 on the edge where reset is sampled high). Requests presented during reset are not accepted.

## Configuration
- RF_WB_FWD_EN defined:
  - rsN_fwd_hit = wr_en && (wr_addr==rsN_addr) && (rsN_addr!=0), combinational.
  - rsN_fwd_data = wr_data.
- RF_WB_FWD_EN undefined:
  - the rs*_addr inputs are ignored;
  - rs*_fwd_hit are tied to 0 and rs*_fwd_data to 0;
  - no comparators are synthesised.

## Test plan
- Reset, then req_valid=3'b111 held for 6 cycles with distinct addresses -> grants in order 0,1,2,0,1,2. Each wr_en=1 one cycle after its grant with the matching addr/data.
- req_valid[1]=1 only, addr=5, data=0xDEADBEEF -> req_ready=3'b010. Next cycle: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=1.
- Requester 2 writes addr=0, data=0x1234 -> req_ready[2] pulses; next cycle wr_en=0 and wr_addr/wr_data unchanged. A following all-valid cycle grants requester 0.
- wb_stall=1 for 3 cycles with all valid -> req_ready=0 and wr_en=0 throughout. After the stall drops, the grant continues from the saved pointer.
- Reset asserted in the cycle after a grant to addr=7 -> wr_en=0 on that edge. Then, with all valid, the first grant is requester 0.
- With RF_WB_FWD_EN, write addr=9 in flight and rs1_addr=9, rs2_addr=0 -> rs1_fwd_hit=1, rs1_fwd_data=wr_data, rs2_fwd_hit=0. Without RF_WB_FWD_EN, both hit outputs are 0.
